word_aligner: RTL and testbench

WORD_ALIGNER -- requirements
Module: word_aligner

---
 rtl/wa_pkg.sv | 25 ++
 rtl/comma_finder.sv | 28 ++
 rtl/word_aligner.sv | 174 +++++++++++++++++
 tb/tb_word_aligner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wa_pkg.sv
// Shared constants and state encoding for the K28.5 word aligner.
package wa_pkg;

    localparam int unsigned WORD_W = 10;
    localparam int unsigned WIN_W  = 2 * WORD_W;
    localparam int unsigned OFF_W  = 4;

    localparam logic [WORD_W-1:0] K28_5_P = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28_5_N = 10'b1100000101;

    typedef logic [1:0] wa_state_t;

    localparam wa_state_t ST_HUNT   = 2'd0;
    localparam wa_state_t ST_VERIFY = 2'd1;
    localparam wa_state_t ST_LOCKED = 2'd2;

    function automatic logic is_comma(
        input logic [WORD_W-1:0] word,
        input logic [WORD_W-1:0] pat_p,
        input logic [WORD_W-1:0] pat_n
    );
        return (word == pat_p) || (word == pat_n);
    endfunction

endpackage

// File: rtl/comma_finder.sv
// Combinational comma search over the ten 10-bit slices of a 20-bit window; lowest offset wins.
module comma_finder
    import wa_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P = K28_5_P,
    parameter logic [WORD_W-1:0] COMMA_N = K28_5_N
) (
    input  logic [WIN_W-1:0] window,
    output logic             hit_c,
    output logic [OFF_W-1:0] hit_pos_c
);

    // The top window bit is never part of any slice (max slice is [18:9]).
    logic unused_msb;
    assign unused_msb = window[WIN_W-1];

    always_comb begin
        hit_c     = 1'b0;
        hit_pos_c = '0;
        for (int k = 0; k < int'(WORD_W); k++) begin
            if (!hit_c && is_comma(window[k +: WORD_W], COMMA_P, COMMA_N)) begin
                hit_c     = 1'b1;
                hit_pos_c = OFF_W'(k);
            end
        end
    end

endmodule

// File: rtl/word_aligner.sv
// K28.5 word aligner: HUNT/VERIFY/LOCKED comma alignment of a 10-bit parallel stream.
// Optional loss-of-sync detection and los port are built when WA_LOS_DETECT_EN is defined.
module word_aligner
    import wa_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P  = K28_5_P,
    parameter logic [WORD_W-1:0] COMMA_N  = K28_5_N,
    parameter int unsigned       LOCK_CNT = 3,
    parameter int unsigned       LOSS_CNT = 4
) (
    input  logic              clk_1250Mhrz,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              aligned,
    output logic [OFF_W-1:0]  align_pos,
`ifdef WA_LOS_DETECT_EN
    output logic              los,
`endif
    output logic              comma_det
);

    // One counter width covers both the lock and the loss thresholds.
    localparam int unsigned MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    wa_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] prev_q, prev_d;
    logic [OFF_W-1:0]  align_pos_q, align_pos_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              aligned_q, aligned_d;
    logic              comma_det_q, comma_det_d;
`ifdef WA_LOS_DETECT_EN
    logic [CNT_W-1:0]  err_q, err_d;
    logic              los_q, los_d;
`endif

    logic [WIN_W-1:0]  window_c;
    logic              hit_c;
    logic [OFF_W-1:0]  hit_pos_c;
    logic [WORD_W-1:0] slice_c;

    assign window_c = {din, prev_q};

    comma_finder #(
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_comma_finder (
        .window    (window_c),
        .hit_c     (hit_c),
        .hit_pos_c (hit_pos_c)
    );

    // Select the slice at the frozen alignment offset.
    always_comb begin
        slice_c = '0;
        for (int k = 0; k < int'(WORD_W); k++) begin
            if (align_pos_q == OFF_W'(k)) begin
                slice_c = window_c[k +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        align_pos_d  = align_pos_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        comma_det_d  = 1'b0;
`ifdef WA_LOS_DETECT_EN
        err_d        = err_q;
        los_d        = 1'b0;
`endif

        if (din_valid) begin
            prev_d = din;

            // Output follows the state held at the start of the cycle, so the lock cycle emits nothing.
            if (state_q == ST_LOCKED) begin
                dout_d       = slice_c;
                dout_valid_d = 1'b1;
                comma_det_d  = is_comma(slice_c, COMMA_P, COMMA_N);
            end

            case (state_q)
                ST_HUNT: begin
                    if (hit_c) begin
                        align_pos_d = hit_pos_c;
                        cnt_d       = CNT_W'(1);
                        state_d     = (cnt_d >= CNT_W'(LOCK_CNT)) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (hit_c) begin
                        if (hit_pos_c == align_pos_q) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            align_pos_d = hit_pos_c;
                            cnt_d       = CNT_W'(1);
                        end
                        if (cnt_d >= CNT_W'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
`ifdef WA_LOS_DETECT_EN
                    if (hit_c) begin
                        err_d = (hit_pos_c != align_pos_q) ? err_q + CNT_W'(1) : '0;
                        if (err_d >= CNT_W'(LOSS_CNT)) begin
                            los_d   = 1'b1;
                            err_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_HUNT;
                        end
                    end
`endif
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                end
            endcase
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_1250Mhrz or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HUNT;
            cnt_q        <= '0;
            prev_q       <= '0;
            align_pos_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            aligned_q    <= 1'b0;
            comma_det_q  <= 1'b0;
`ifdef WA_LOS_DETECT_EN
            err_q        <= '0;
            los_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            align_pos_q  <= align_pos_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            aligned_q    <= aligned_d;
            comma_det_q  <= comma_det_d;
`ifdef WA_LOS_DETECT_EN
            err_q        <= err_d;
            los_q        <= los_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign aligned    = aligned_q;
    assign align_pos  = align_pos_q;
    assign comma_det  = comma_det_q;
`ifdef WA_LOS_DETECT_EN
    assign los        = los_q;
`endif

endmodule

// File: tb/tb_word_aligner.sv
// Self-checking bench for word_aligner: directed alignment scenarios plus a random serial bitstream.
module tb_word_aligner;

    localparam logic [9:0] P = 10'b0011111010;
    localparam logic [9:0] N = 10'b1100000101;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 4;

    logic       clk_1250Mhrz;
    logic       rst;
    logic       din_valid;
    logic [9:0] din;
    logic [9:0] dout;
    logic       dout_valid;
    logic       aligned;
    logic [3:0] align_pos;
    logic       comma_det;
`ifdef WA_LOS_DETECT_EN
    logic       los;
`endif

    word_aligner #(
        .COMMA_P  (P),
        .COMMA_N  (N),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk_1250Mhrz (clk_1250Mhrz),
        .rst          (rst),
        .din_valid    (din_valid),
        .din          (din),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .aligned      (aligned),
        .align_pos    (align_pos),
`ifdef WA_LOS_DETECT_EN
        .los          (los),
`endif
        .comma_det    (comma_det)
    );

    initial clk_1250Mhrz = 1'b0;
    always #5 clk_1250Mhrz = ~clk_1250Mhrz;

    int total = 0;
    int bad   = 0;
    int los_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a serial stream cut into words, searched slice by slice.
    logic [9:0] m_prev, m_dout;
    int         m_mode;   // 0 hunting, 1 verifying, 2 locked
    int         m_pos, m_cnt, m_err;
    bit         exp_dv, exp_cd, exp_los;

    task automatic model_reset();
        m_prev = '0; m_dout = '0;
        m_mode = 0; m_pos = 0; m_cnt = 0; m_err = 0;
        exp_dv = 0; exp_cd = 0; exp_los = 0;
    endtask

    task automatic model_step(input bit v, input logic [9:0] d);
        logic [19:0] win;
        logic [9:0]  s;
        int          hit;
        exp_dv = 0; exp_cd = 0; exp_los = 0;
        if (!v) return;
        win = {d, m_prev};
        if (m_mode == 2) begin
            s      = win[m_pos +: 10];
            m_dout = s;
            exp_dv = 1;
            exp_cd = (s == P) || (s == N);
        end
        hit = -1;
        for (int k = 9; k >= 0; k--) begin
            s = win[k +: 10];
            if (s == P || s == N) hit = k;
        end
        if (hit >= 0) begin
            if (m_mode == 0) begin
                m_pos = hit; m_cnt = 1;
                m_mode = (m_cnt >= LOCK_CNT) ? 2 : 1;
            end else if (m_mode == 1) begin
                if (hit == m_pos) m_cnt++;
                else begin m_pos = hit; m_cnt = 1; end
                if (m_cnt >= LOCK_CNT) m_mode = 2;
            end else begin
`ifdef WA_LOS_DETECT_EN
                if (hit != m_pos) m_err++;
                else m_err = 0;
                if (m_err >= LOSS_CNT) begin
                    exp_los = 1; m_err = 0; m_mode = 0;
                end
`endif
            end
        end
        m_prev = d;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".dout"},       32'(dout),       32'(m_dout));
        chk({ph, ".dout_valid"}, 32'(dout_valid), 32'(exp_dv));
        chk({ph, ".comma_det"},  32'(comma_det),  32'(exp_cd));
        chk({ph, ".aligned"},    32'(aligned),    32'(m_mode == 2));
        chk({ph, ".align_pos"},  32'(align_pos),  32'(m_pos));
`ifdef WA_LOS_DETECT_EN
        chk({ph, ".los"},        32'(los),        32'(exp_los));
        if (los) los_pulses++;
`endif
    endtask

    task automatic step(input string ph, input bit v, input logic [9:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk_1250Mhrz);
        model_step(v, d);
        #1;
        check_all(ph);
    endtask

    // Serial bit queue, earliest bit first; each word takes bit i from the i-th popped bit.
    bit bq[$];

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) bq.push_back(w[i]);
    endtask

    task automatic push_bits(input int n, input bit rnd);
        for (int i = 0; i < n; i++) bq.push_back(rnd ? 1'($urandom_range(1)) : 1'b0);
    endtask

    task automatic feed_word(input string ph);
        logic [9:0] w;
        if (bq.size() < 10) begin
            total++; bad++;
            $display("FAIL %s.stream: got=%0d bits expected>=10", ph, bq.size());
            w = '0;
        end else begin
            for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
        end
        step(ph, 1'b1, w);
    endtask

    task automatic do_reset(input string ph);
        @(posedge clk_1250Mhrz);
        #3;
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        chk({ph, ".rst_dout"},      32'(dout),       32'h0);
        chk({ph, ".rst_dout_valid"},32'(dout_valid), 32'h0);
        chk({ph, ".rst_comma_det"}, 32'(comma_det),  32'h0);
        chk({ph, ".rst_aligned"},   32'(aligned),    32'h0);
        chk({ph, ".rst_align_pos"}, 32'(align_pos),  32'h0);
`ifdef WA_LOS_DETECT_EN
        chk({ph, ".rst_los"},       32'(los),        32'h0);
`endif
        model_reset();
        bq.delete();
        repeat (2) @(posedge clk_1250Mhrz);
        @(negedge clk_1250Mhrz);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = '0;
        model_reset();
        #2;
        do_reset("init");
        for (int i = 0; i < 4; i++) step("idle", 1'b0, 10'($urandom));

        // Repeated comma shifted by 3 bits: lock after the third complete comma.
        do_reset("shift3");
        push_bits(3, 1'b0);
        for (int i = 0; i < 8; i++) push_word(P);
        for (int i = 0; i < 3; i++) feed_word("shift3");
        chk("shift3.not_yet_locked", 32'(aligned), 32'h0);
        feed_word("shift3");
        chk("shift3.locked",     32'(aligned),    32'h1);
        chk("shift3.pos",        32'(align_pos),  32'd3);
        chk("shift3.lock_cyc_dv",32'(dout_valid), 32'h0);
        feed_word("shift3");
        chk("shift3.dout",       32'(dout),       32'(P));
        chk("shift3.comma_det",  32'(comma_det),  32'h1);

        // Two commas at 3, then the stream slips to 7: verification restarts.
        do_reset("slip7");
        push_bits(3, 1'b0);
        push_word(P); push_word(P);
        push_bits(4, 1'b0);
        for (int i = 0; i < 6; i++) push_word(P);
        for (int i = 0; i < 4; i++) feed_word("slip7");
        chk("slip7.restart_pos", 32'(align_pos), 32'd7);
        chk("slip7.restart_unl", 32'(aligned),   32'h0);
        feed_word("slip7");
        chk("slip7.cnt2_unl",    32'(aligned),   32'h0);
        feed_word("slip7");
        chk("slip7.locked",      32'(aligned),   32'h1);
        chk("slip7.pos",         32'(align_pos), 32'd7);

        // Gapped valid while locked.
        for (int i = 0; i < 10; i++) push_word(P);
        for (int i = 0; i < 8; i++) begin
            feed_word("gap");
            step("gap", 1'b0, 10'($urandom));
            chk("gap.idle_dv",  32'(dout_valid), 32'h0);
            chk("gap.idle_lock",32'(aligned),    32'h1);
        end

        // Locked at 3, then four commas at offset 5.
        do_reset("loss");
        los_pulses = 0;
        push_bits(3, 1'b0);
        for (int i = 0; i < 5; i++) push_word(P);
        push_bits(2, 1'b0);
        for (int i = 0; i < 6; i++) push_word(P);
        push_bits(8, 1'b0);
        for (int i = 0; i < 12; i++) feed_word("loss");
`ifdef WA_LOS_DETECT_EN
        chk("loss.los_pulses", 32'(los_pulses), 32'd1);
        chk("loss.aligned",    32'(aligned),    32'h0);
`else
        chk("loss.sticky",     32'(aligned),    32'h1);
`endif

        // Reset while locked clears everything at once; relock needs LOCK_CNT commas again.
        do_reset("relock_a");
        push_bits(3, 1'b0);
        for (int i = 0; i < 6; i++) push_word(P);
        for (int i = 0; i < 5; i++) feed_word("relock_a");
        chk("relock.pre", 32'(aligned), 32'h1);
        do_reset("relock");
        push_bits(3, 1'b0);
        for (int i = 0; i < 6; i++) push_word(N);
        for (int i = 0; i < 3; i++) feed_word("relock");
        chk("relock.partial", 32'(aligned), 32'h0);
        feed_word("relock");
        chk("relock.locked",  32'(aligned), 32'h1);

        // Random stream: commas of both disparities, data words and bit slips.
        do_reset("rand");
        for (int n = 0; n < 3000; n++) begin
            while (bq.size() < 40) begin
                int r;
                r = int'($urandom_range(9));
                if (r <= 5)      push_word($urandom_range(1) ? P : N);
                else if (r <= 7) push_word(10'($urandom));
                else if (r == 8) push_bits(int'($urandom_range(1, 9)), 1'b1);
                else             push_bits(int'($urandom_range(1, 9)), 1'b0);
            end
            if ($urandom_range(4) == 0) step("rand", 1'b0, 10'($urandom));
            else                        feed_word("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
